// File: rtl/sfifo_arb_pkg.sv
// sfifo_arb_pkg
// Shared definitions for the FIFO write arbiter slice:
//   arb_state_t   - arbiter state encoding (IDLE, GRANT)
//   DW_DEFAULT    - default producer/FIFO data width
//   DEPTH_DEFAULT - default FIFO depth (credit limit)
//   level_width() - bit width of a 0..depth occupancy counter
package sfifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int unsigned DW_DEFAULT    = 8;
   localparam int unsigned DEPTH_DEFAULT = 16;

   // Occupancy must represent the full value 'depth', hence the extra bit.
   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sfifo_rr_pick.sv
// sfifo_rr_pick
// Combinational circular priority picker: returns the first asserted
// request at or after rr_ptr, wrapping from NREQ-1 back to 0.
// Ports:
//   req_valid [NREQ]        request vector
//   rr_ptr    [clog2 NREQ]  search start position
//   pick_id   [clog2 NREQ]  chosen index (0 when nothing is valid)
//   pick_any                at least one request is valid
module sfifo_rr_pick
   import sfifo_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         req_valid,
   input  logic [$clog2(NREQ)-1:0] rr_ptr,
   output logic [$clog2(NREQ)-1:0] pick_id,
   output logic                    pick_any
);

   localparam int unsigned IW = $clog2(NREQ);

   always_comb begin
      pick_id  = '0;
      pick_any = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!pick_any && req_valid[IW'((32'(rr_ptr) + k) % NREQ)]) begin
            pick_id  = IW'((32'(rr_ptr) + k) % NREQ);
            pick_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sfifo_wr_arbiter.sv
// sfifo_wr_arbiter
// Round-robin write arbiter in front of a DEPTH-deep synchronous FIFO.
// Grants one producer at a time, registers the FIFO write strobe/data and
// tracks occupancy with a private credit counter so the FIFO's own 'full'
// flag is never needed.
// Build option: define SFIFO_ARB_BURST_EN to keep a grant for up to
// MAX_BURST accepted beats; otherwise every grant ends after one beat.
// Ports:
//   CLK, RSTn   clock, synchronous active-low reset
//   req_valid   per-producer valid
//   req_data    packed producer data, slice i = [i*DW +: DW]
//   req_ready   one-hot/zero ready back to the producers
//   fifo_read   consumer read strobe seen by the FIFO
//   fifo_write  registered FIFO write strobe
//   fifo_data   registered FIFO write data
//   grant_id    current or last granted producer
//   level       credit-tracked FIFO occupancy (0..DEPTH)
//   busy        high while a grant is held
module sfifo_wr_arbiter
   import sfifo_arb_pkg::*;
#(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DW        = DW_DEFAULT,
   parameter int unsigned DEPTH     = DEPTH_DEFAULT,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                          CLK,
   input  logic                          RSTn,
   input  logic [NREQ-1:0]               req_valid,
   input  logic [NREQ*DW-1:0]            req_data,
   output logic [NREQ-1:0]               req_ready,
   input  logic                          fifo_read,
   output logic                          fifo_write,
   output logic [DW-1:0]                 fifo_data,
   output logic [$clog2(NREQ)-1:0]       grant_id,
   output logic [level_width(DEPTH)-1:0] level,
   output logic                          busy
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned LW = level_width(DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [IW-1:0] LAST_ID  = IW'(NREQ - 1);

   if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1) begin : g_bad_cfg
      $error("sfifo_wr_arbiter: NREQ must be 2..8 and MAX_BURST at least 1");
   end

   arb_state_t    state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] pick_id;
   logic          pick_any;
   logic          accept;
   logic          rd_cnt;
   logic          release_grant;

   sfifo_rr_pick #(.NREQ(NREQ)) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .pick_id   (pick_id),
      .pick_any  (pick_any)
   );

   // Ready depends only on state, grant and credit, never on req_valid.
   always_comb begin
      req_ready = '0;
      if (state == GRANT && level < FULL_LVL) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   assign busy   = (state == GRANT);
   assign accept = |(req_valid & req_ready);
   assign rd_cnt = fifo_read && (level != '0);

`ifdef SFIFO_ARB_BURST_EN
   localparam int unsigned BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

   logic [BW-1:0] beat;

   // Credit stalls leave 'beat' untouched, so only accepted beats count.
   assign release_grant = !req_valid[grant_id] || (accept && beat == LAST_BEAT);

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         beat <= '0;
      end else if (state == GRANT) begin
         if (release_grant) begin
            beat <= '0;
         end else if (accept) begin
            beat <= beat + 1'b1;
         end
      end
   end
`else
   assign release_grant = !req_valid[grant_id] || accept;
`endif

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         grant_id   <= '0;
         level      <= '0;
         fifo_write <= 1'b0;
         fifo_data  <= '0;
      end else begin
         fifo_write <= accept;
         if (accept) begin
            fifo_data <= req_data[grant_id*DW +: DW];
         end

         case ({accept, rd_cnt})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase

         case (state)
            IDLE: begin
               if (pick_any) begin
                  grant_id <= pick_id;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (release_grant) begin
                  rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sfifo_wr_arbiter.sv
// tb_sfifo_wr_arbiter
// Directed bench for sfifo_wr_arbiter (NREQ=4, DW=8, DEPTH=16, MAX_BURST=4).
// Table vectors cover reset, single beat and round-robin order; hand-written
// sequences cover the credit limit, resets and (with SFIFO_ARB_BURST_EN)
// burst grants.
module tb_sfifo_wr_arbiter;

   localparam logic [31:0] D = 32'h4433A511;   // slices: 0=11 1=A5 2=33 3=44

   logic        CLK = 1'b0;
   logic        RSTn;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_read;
   logic        fifo_write;
   logic [7:0]  fifo_data;
   logic [1:0]  grant_id;
   logic [4:0]  level;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   sfifo_wr_arbiter #(
      .NREQ      (4),
      .DW        (8),
      .DEPTH     (16),
      .MAX_BURST (4)
   ) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_read  (fifo_read),
      .fifo_write (fifo_write),
      .fifo_data  (fifo_data),
      .grant_id   (grant_id),
      .level      (level),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       rstn;
      logic [3:0] valid;
      logic       rd;
      logic [3:0] e_ready;
      logic       e_write;
      logic [7:0] e_data;
      logic [1:0] e_grant;
      logic [4:0] e_level;
      logic       e_busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic [3:0] v, input logic rd,
                               input logic [3:0] er, input logic ew, input logic [7:0] ed,
                               input logic [1:0] eg, input logic [4:0] el, input logic eb);
      vec_t x;
      x.rstn = r; x.valid = v; x.rd = rd;
      x.e_ready = er; x.e_write = ew; x.e_data = ed;
      x.e_grant = eg; x.e_level = el; x.e_busy = eb;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] rdy, input logic wr,
                          input logic [7:0] d, input logic [1:0] g, input logic [4:0] l,
                          input logic b);
      chk({tag, ".ready"}, 32'(req_ready),  32'(rdy));
      chk({tag, ".write"}, 32'(fifo_write), 32'(wr));
      chk({tag, ".data"},  32'(fifo_data),  32'(d));
      chk({tag, ".grant"}, 32'(grant_id),   32'(g));
      chk({tag, ".level"}, 32'(level),      32'(l));
      chk({tag, ".busy"},  32'(busy),       32'(b));
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acc_edge[$];
      int acc_gid[$];
      int exp_edge[6];
      int exp_gid[6];

      RSTn      = 1'b0;
      req_valid = 4'b1111;
      req_data  = D;
      fifo_read = 1'b1;

      // rstn, valid, rd -> ready, write, data, grant, level, busy
      vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
`ifndef SFIFO_ARB_BURST_EN
      vecs.push_back(mk(1, 4'b0010, 0, 4'b0010, 0, 8'h00, 1, 0, 1));
      vecs.push_back(mk(1, 4'b0010, 0, 4'b0000, 1, 8'hA5, 1, 1, 0));
      vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 8'hA5, 1, 1, 0));
      vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 8'hA5, 1, 0, 0));
      vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 8'hA5, 1, 0, 0));
      vecs.push_back(mk(1, 4'b1111, 0, 4'b0100, 0, 8'hA5, 2, 0, 1));
      vecs.push_back(mk(1, 4'b1111, 0, 4'b0000, 1, 8'h33, 2, 1, 0));
      vecs.push_back(mk(1, 4'b1111, 0, 4'b1000, 0, 8'h33, 3, 1, 1));
      vecs.push_back(mk(1, 4'b1111, 0, 4'b0000, 1, 8'h44, 3, 2, 0));
      vecs.push_back(mk(1, 4'b1111, 0, 4'b0001, 0, 8'h44, 0, 2, 1));
      vecs.push_back(mk(1, 4'b1111, 0, 4'b0000, 1, 8'h11, 0, 3, 0));
      vecs.push_back(mk(1, 4'b1111, 0, 4'b0010, 0, 8'h11, 1, 3, 1));
      vecs.push_back(mk(1, 4'b1111, 0, 4'b0000, 1, 8'hA5, 1, 4, 0));
      vecs.push_back(mk(1, 4'b1111, 0, 4'b0100, 0, 8'hA5, 2, 4, 1));
      vecs.push_back(mk(1, 4'b1111, 1, 4'b0000, 1, 8'h33, 2, 4, 0));
      vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 8'h33, 2, 3, 0));
      vecs.push_back(mk(1, 4'b0001, 0, 4'b0001, 0, 8'h33, 0, 3, 1));
      vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 8'h33, 0, 3, 0));
      vecs.push_back(mk(1, 4'b1111, 0, 4'b0010, 0, 8'h33, 1, 3, 1));
      vecs.push_back(mk(1, 4'b0000, 0, 4'b0000, 0, 8'h33, 1, 3, 0));
`endif

      foreach (vecs[i]) begin
         RSTn      = vecs[i].rstn;
         req_valid = vecs[i].valid;
         fifo_read = vecs[i].rd;
         step();
         chk_out($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_write,
                 vecs[i].e_data, vecs[i].e_grant, vecs[i].e_level, vecs[i].e_busy);
      end

      // Drain any credits, then stream producer 0 into a FIFO nobody reads.
      req_valid = 4'b0000;
      fifo_read = 1'b1;
      for (int i = 0; i < 5; i++) step();
      fifo_read = 1'b0;
      chk("drain.level", 32'(level), 32'd0);

      req_data  = 32'h4433A55A;
      req_valid = 4'b0001;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (fifo_write) n++;
      end
      chk("credit.accepts", 32'(n), 32'd16);
      chk("credit.level",   32'(level), 32'd16);
      chk("credit.ready",   32'(req_ready), 32'd0);
      chk("credit.busy",    32'(busy), 32'd1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (fifo_write) n++;
      end
      chk("credit.stall_writes", 32'(n), 32'd0);

      fifo_read = 1'b1;
      step();
      fifo_read = 1'b0;
      chk("credit.read_level", 32'(level), 32'd15);
      chk("credit.read_ready", 32'(req_ready), 32'b0001);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (fifo_write) n++;
      end
      chk("credit.extra_accepts", 32'(n), 32'd1);
      chk("credit.final_level",   32'(level), 32'd16);
      chk("credit.final_data",    32'(fifo_data), 32'h5A);

      // Reset from a full, stalled grant.
      RSTn = 1'b0;
      step();
      chk_out("rst_full", 4'b0000, 0, 8'h00, 0, 0, 0);
      RSTn      = 1'b1;
      req_valid = 4'b0000;
      fifo_read = 1'b1;
      step();
      fifo_read = 1'b0;
      chk("empty_read.level", 32'(level), 32'd0);

      // Reset while a beat is being offered on a live grant.
      req_data  = D;
      req_valid = 4'b0100;
      for (int i = 0; i < 3; i++) step();
      chk("midgrant.busy",  32'(busy), 32'd1);
      chk("midgrant.ready", 32'(req_ready), 32'b0100);
      RSTn = 1'b0;
      step();
      chk_out("rst_mid", 4'b0000, 0, 8'h00, 0, 0, 0);
      RSTn      = 1'b1;
      req_valid = 4'b0000;
      step();
      chk("rst_mid.no_write", 32'(fifo_write), 32'd0);

`ifdef SFIFO_ARB_BURST_EN
      exp_edge = '{2, 3, 4, 5, 7, 8};

      // Producer 2 alone for six beats: 4-beat burst, bubble, 2 more beats.
      req_valid = 4'b0100;
      for (int e = 1; e <= 20; e++) begin
         if (|(req_valid & req_ready)) acc_edge.push_back(e);
         step();
         if (acc_edge.size() == 6) req_valid = 4'b0000;
      end
      chk("burst1.count", 32'(acc_edge.size()), 32'd6);
      for (int i = 0; i < 6 && i < acc_edge.size(); i++)
         chk($sformatf("burst1.edge%0d", i), 32'(acc_edge[i]), 32'(exp_edge[i]));
      chk("burst1.level", 32'(level), 32'd6);

      RSTn = 1'b0;
      step();
      RSTn = 1'b1;

      // Producers 2 and 3: the grant moves to 3 after four beats from 2.
      exp_gid = '{2, 2, 2, 2, 3, 3};
      acc_edge.delete();
      req_valid = 4'b1100;
      for (int e = 1; e <= 20; e++) begin
         if (|(req_valid & req_ready) && acc_gid.size() < 6) begin
            acc_edge.push_back(e);
            acc_gid.push_back(int'(grant_id));
         end
         step();
      end
      req_valid = 4'b0000;
      chk("burst2.count", 32'(acc_gid.size()), 32'd6);
      for (int i = 0; i < 6 && i < acc_gid.size(); i++) begin
         chk($sformatf("burst2.gid%0d", i),  32'(acc_gid[i]),  32'(exp_gid[i]));
         chk($sformatf("burst2.edge%0d", i), 32'(acc_edge[i]), 32'(exp_edge[i]));
      end
`else
      exp_edge = '{0, 0, 0, 0, 0, 0};
      exp_gid  = '{0, 0, 0, 0, 0, 0};
      acc_edge.delete();
      acc_gid.delete();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
